dsp_branch_unit: RTL and testbench

//  Parametrised branch-resolution unit for the DSP receiver core, sitting after the ALU stage.

---
 rtl/dsp_branch_unit.sv | 200 ++++++++++++++++++++
 tb/tb_dsp_branch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dsp_branch_unit.sv
// Branch-resolution unit: conditional/unconditional redirects plus a hardware loop stack.
// Optional call/return stack is compiled in when DSP_BRANCH_CALL_EN is defined.
module dsp_branch_unit #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int CNT_W      = 12,
    parameter int LOOP_DEPTH = 4,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_in,
    input  logic                              stall,
    input  logic [2:0]                        flow_mode,
    input  logic [DATA_W-1:0]                 alu_result,
    input  logic [ADDR_W-1:0]                 pc,
    input  logic [ADDR_W-1:0]                 target_addr,
    output logic                              jump_flag,
    output logic [ADDR_W-1:0]                 jump_addr,
    output logic                              flush,
    output logic                              loop_active,
    output logic [$clog2(LOOP_DEPTH+1)-1:0]   loop_level,
    output logic                              err_overflow,
    output logic                              err_underflow
);

    localparam int LVL_W = $clog2(LOOP_DEPTH + 1);
    localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

    typedef enum logic [2:0] {
        MODE_NONE = 3'd0,
        MODE_BEZ  = 3'd1,
        MODE_BNEZ = 3'd2,
        MODE_BLTZ = 3'd3,
        MODE_JMP  = 3'd4,
        MODE_LOOP = 3'd5,
        MODE_CALL = 3'd6,
        MODE_RET  = 3'd7
    } flow_mode_e;

    flow_mode_e mode;
    assign mode = flow_mode_e'(flow_mode);

    logic [ADDR_W-1:0] loop_start [LOOP_DEPTH];
    logic [ADDR_W-1:0] loop_end   [LOOP_DEPTH];
    logic [CNT_W-1:0]  loop_cnt   [LOOP_DEPTH];
    logic [LVL_W-1:0]  level_q;

    logic              accept;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  push_idx;
    logic              loop_full;
    logic              at_end;
    logic [CNT_W-1:0]  cnt_in;
    logic              branch_taken;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              loop_push;
    logic              loop_pop;
    logic              loop_dec;
    logic              set_ovf;
    logic              set_unf;

    assign accept    = valid_in && !stall;
    assign top_idx   = IDX_W'(level_q - LVL_W'(1));
    assign push_idx  = IDX_W'(level_q);
    assign loop_full = (level_q == LVL_W'(LOOP_DEPTH));
    assign cnt_in    = alu_result[CNT_W-1:0];

    assign loop_active = (level_q != '0);
    assign loop_level  = level_q;
    assign flush       = jump_flag;

`ifdef DSP_BRANCH_CALL_EN
    localparam int RAS_LVL_W = $clog2(RAS_DEPTH + 1);
    localparam int RAS_IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0]    ras_stack [RAS_DEPTH];
    logic [RAS_LVL_W-1:0] ras_level;
    logic [RAS_IDX_W-1:0] ras_top;
    logic [RAS_IDX_W-1:0] ras_push_idx;
    logic                 ras_full;
    logic                 ras_empty;
    logic                 ras_push;
    logic                 ras_pop;

    assign ras_top      = RAS_IDX_W'(ras_level - RAS_LVL_W'(1));
    assign ras_push_idx = RAS_IDX_W'(ras_level);
    assign ras_full     = (ras_level == RAS_LVL_W'(RAS_DEPTH));
    assign ras_empty    = (ras_level == '0);
`endif

    // A LOOP instruction or a taken redirect suppresses the loop-end check for that cycle.
    always_comb begin
        at_end        = loop_active && (pc == loop_end[top_idx]);
        branch_taken  = 1'b0;
        redirect      = 1'b0;
        redirect_addr = target_addr;
        loop_push     = 1'b0;
        loop_pop      = 1'b0;
        loop_dec      = 1'b0;
        set_ovf       = 1'b0;
        set_unf       = 1'b0;
`ifdef DSP_BRANCH_CALL_EN
        ras_push      = 1'b0;
        ras_pop       = 1'b0;
`endif
        case (mode)
            MODE_BEZ:  branch_taken = (alu_result == '0);
            MODE_BNEZ: branch_taken = (alu_result != '0);
            MODE_BLTZ: branch_taken = alu_result[DATA_W-1];
            MODE_JMP:  branch_taken = 1'b1;
            default:   branch_taken = 1'b0;
        endcase

        if (accept) begin
            if (mode == MODE_LOOP) begin
                if (cnt_in == '0) begin
                    redirect      = 1'b1;
                    redirect_addr = target_addr + ADDR_W'(1);
                end else if (loop_full) begin
                    set_ovf = 1'b1;
                end else begin
                    loop_push = 1'b1;
                end
            end else if (branch_taken) begin
                redirect      = 1'b1;
                redirect_addr = target_addr;
            end
`ifdef DSP_BRANCH_CALL_EN
            else if (mode == MODE_CALL) begin
                redirect      = 1'b1;
                redirect_addr = target_addr;
                if (ras_full) set_ovf = 1'b1;
                else          ras_push = 1'b1;
            end else if (mode == MODE_RET && !ras_empty) begin
                redirect      = 1'b1;
                redirect_addr = ras_stack[ras_top];
                ras_pop       = 1'b1;
            end
`endif
            else begin
                if (mode == MODE_CALL || mode == MODE_RET) set_unf = 1'b1;
                if (at_end) begin
                    if (loop_cnt[top_idx] > CNT_W'(1)) begin
                        loop_dec      = 1'b1;
                        redirect      = 1'b1;
                        redirect_addr = loop_start[top_idx];
                    end else begin
                        loop_pop = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jump_flag     <= 1'b0;
            jump_addr     <= '0;
            level_q       <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                loop_start[i] <= '0;
                loop_end[i]   <= '0;
                loop_cnt[i]   <= '0;
            end
        end else begin
            jump_flag <= redirect;
            if (redirect) jump_addr <= redirect_addr;
            if (set_ovf)  err_overflow  <= 1'b1;
            if (set_unf)  err_underflow <= 1'b1;
            if (loop_push) begin
                loop_start[push_idx] <= pc + ADDR_W'(1);
                loop_end[push_idx]   <= target_addr;
                loop_cnt[push_idx]   <= cnt_in;
                level_q              <= level_q + LVL_W'(1);
            end else if (loop_pop) begin
                level_q <= level_q - LVL_W'(1);
            end
            if (loop_dec) loop_cnt[top_idx] <= loop_cnt[top_idx] - CNT_W'(1);
        end
    end

`ifdef DSP_BRANCH_CALL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ras_level <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_stack[i] <= '0;
        end else if (ras_push) begin
            ras_stack[ras_push_idx] <= pc + ADDR_W'(1);
            ras_level               <= ras_level + RAS_LVL_W'(1);
        end else if (ras_pop) begin
            ras_level <= ras_level - RAS_LVL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dsp_branch_unit.sv
// Self-checking bench for dsp_branch_unit: vector table through a scoreboard queue,
// plus hand sequences for nesting overflow, reset mid-loop and call/return.
module tb_dsp_branch_unit;

    localparam logic [2:0] M_NONE = 3'd0;
    localparam logic [2:0] M_BEZ  = 3'd1;
    localparam logic [2:0] M_BNEZ = 3'd2;
    localparam logic [2:0] M_BLTZ = 3'd3;
    localparam logic [2:0] M_JMP  = 3'd4;
    localparam logic [2:0] M_LOOP = 3'd5;
    localparam logic [2:0] M_CALL = 3'd6;
    localparam logic [2:0] M_RET  = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        stall;
    logic [2:0]  flow_mode;
    logic [15:0] alu_result;
    logic [15:0] pc;
    logic [15:0] target_addr;
    logic        jump_flag;
    logic [15:0] jump_addr;
    logic        flush;
    logic        loop_active;
    logic [2:0]  loop_level;
    logic        err_overflow;
    logic        err_underflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        valid;
        logic        stl;
        logic [2:0]  mode;
        logic [15:0] alu;
        logic [15:0] pc;
        logic [15:0] tgt;
        logic        exp_jump;
        logic [15:0] exp_addr;
        logic [2:0]  exp_level;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    dsp_branch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .stall         (stall),
        .flow_mode     (flow_mode),
        .alu_result    (alu_result),
        .pc            (pc),
        .target_addr   (target_addr),
        .jump_flag     (jump_flag),
        .jump_addr     (jump_addr),
        .flush         (flush),
        .loop_active   (loop_active),
        .loop_level    (loop_level),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s scoreboard: got empty queue expected one entry", tag);
            return;
        end
        e = exp_q.pop_front();
        checkVal({tag, " jump_flag"}, 32'(jump_flag), 32'(e.exp_jump));
        checkVal({tag, " flush"}, 32'(flush), 32'(e.exp_jump));
        if (e.exp_jump) checkVal({tag, " jump_addr"}, 32'(jump_addr), 32'(e.exp_addr));
        checkVal({tag, " loop_level"}, 32'(loop_level), 32'(e.exp_level));
        checkVal({tag, " loop_active"}, 32'(loop_active), 32'(e.exp_level != 3'd0));
    endtask

    // Inputs change on the falling edge; registered results are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        valid_in    = v.valid;
        stall       = v.stl;
        flow_mode   = v.mode;
        alu_result  = v.alu;
        pc          = v.pc;
        target_addr = v.tgt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst = 1'b0; valid_in = 1'b0; stall = 1'b0; flow_mode = M_NONE;
        alu_result = '0; pc = '0; target_addr = '0;

        // {valid, stall, mode, alu, pc, target, exp_jump, exp_addr, exp_level}
        vecs.push_back('{1'b1, 1'b0, M_BEZ,  16'h0000, 16'h0001, 16'h0040, 1'b1, 16'h0040, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0002, 16'h0000, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_BNEZ, 16'h0000, 16'h0003, 16'h0044, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_BNEZ, 16'h0005, 16'h0004, 16'h0050, 1'b1, 16'h0050, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_BLTZ, 16'h8000, 16'h0005, 16'h0060, 1'b1, 16'h0060, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_BLTZ, 16'h7FFF, 16'h0006, 16'h0070, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_BEZ,  16'h0001, 16'h0007, 16'h0074, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_JMP,  16'h0007, 16'h0008, 16'h1234, 1'b1, 16'h1234, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_LOOP, 16'h0003, 16'h0010, 16'h0013, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0011, 16'h0000, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0012, 16'h0000, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0013, 16'h0000, 1'b1, 16'h0011, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0011, 16'h0000, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0012, 16'h0000, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0013, 16'h0000, 1'b1, 16'h0011, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0011, 16'h0000, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0012, 16'h0000, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0013, 16'h0000, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_LOOP, 16'h0000, 16'h0010, 16'h0013, 1'b1, 16'h0014, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_LOOP, 16'h0000, 16'h0020, 16'hFFFF, 1'b1, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_LOOP, 16'h1000, 16'h0030, 16'h0035, 1'b1, 16'h0036, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_LOOP, 16'h0002, 16'h0040, 16'h0042, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b1, M_NONE, 16'h0000, 16'h0042, 16'h0000, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b0, 1'b0, M_NONE, 16'h0000, 16'h0042, 16'h0000, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_JMP,  16'h0000, 16'h0042, 16'h0100, 1'b1, 16'h0100, 3'd1});
        vecs.push_back('{1'b1, 1'b1, M_JMP,  16'h0000, 16'h0042, 16'h0100, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0042, 16'h0000, 1'b1, 16'h0041, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0041, 16'h0000, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_BEZ,  16'h0001, 16'h0042, 16'h0200, 1'b0, 16'h0000, 3'd0});
        vecs.push_back('{1'b1, 1'b0, M_LOOP, 16'h0002, 16'h0050, 16'h0060, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_LOOP, 16'h0001, 16'h0060, 16'h0062, 1'b0, 16'h0000, 3'd2});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0062, 16'h0000, 1'b0, 16'h0000, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0060, 16'h0000, 1'b1, 16'h0051, 3'd1});
        vecs.push_back('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0060, 16'h0000, 1'b0, 16'h0000, 3'd0});

        repeat (3) @(negedge clk);
        checkVal("reset jump_flag", 32'(jump_flag), 32'd0);
        checkVal("reset flush", 32'(flush), 32'd0);
        checkVal("reset jump_addr", 32'(jump_addr), 32'd0);
        checkVal("reset loop_level", 32'(loop_level), 32'd0);
        checkVal("reset loop_active", 32'(loop_active), 32'd0);
        checkVal("reset err_overflow", 32'(err_overflow), 32'd0);
        checkVal("reset err_underflow", 32'(err_underflow), 32'd0);
        rst = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Nest one loop more than the stack holds.
        for (int i = 0; i < 4; i++)
            applyStimulus('{1'b1, 1'b0, M_LOOP, 16'h0005, 16'(16'h0200 + i), 16'(16'h02FF - i),
                            1'b0, 16'h0000, 3'(i + 1)}, $sformatf("nest%0d", i));
        checkVal("nest no overflow yet", 32'(err_overflow), 32'd0);
        applyStimulus('{1'b1, 1'b0, M_LOOP, 16'h0005, 16'h0204, 16'h02FB, 1'b0, 16'h0000, 3'd4}, "nest4");
        checkVal("overflow set", 32'(err_overflow), 32'd1);
        applyStimulus('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h0205, 16'h0000, 1'b0, 16'h0000, 3'd4}, "after_ovf");
        checkVal("overflow sticky", 32'(err_overflow), 32'd1);
        applyStimulus('{1'b1, 1'b0, M_JMP, 16'h0000, 16'h0206, 16'h0400, 1'b1, 16'h0400, 3'd4}, "jmp_pre_reset");

        // Asynchronous reset while a redirect pulse and nested loops are live.
        #2;
        rst = 1'b0;
        valid_in = 1'b0;
        #1;
        checkVal("midreset jump_flag", 32'(jump_flag), 32'd0);
        checkVal("midreset flush", 32'(flush), 32'd0);
        checkVal("midreset loop_level", 32'(loop_level), 32'd0);
        checkVal("midreset loop_active", 32'(loop_active), 32'd0);
        checkVal("midreset err_overflow", 32'(err_overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h02FC, 16'h0000, 1'b0, 16'h0000, 3'd0}, "post_reset0");
        applyStimulus('{1'b1, 1'b0, M_NONE, 16'h0000, 16'h02FF, 16'h0000, 1'b0, 16'h0000, 3'd0}, "post_reset1");

        checkVal("underflow clear", 32'(err_underflow), 32'd0);
`ifdef DSP_BRANCH_CALL_EN
        applyStimulus('{1'b1, 1'b0, M_CALL, 16'h0000, 16'h0020, 16'h0080, 1'b1, 16'h0080, 3'd0}, "call");
        applyStimulus('{1'b1, 1'b0, M_RET,  16'h0000, 16'h0085, 16'h0000, 1'b1, 16'h0021, 3'd0}, "ret");
        checkVal("underflow after ret", 32'(err_underflow), 32'd0);
        applyStimulus('{1'b1, 1'b0, M_RET,  16'h0000, 16'h0086, 16'h0000, 1'b0, 16'h0000, 3'd0}, "ret_empty");
        checkVal("underflow ret empty", 32'(err_underflow), 32'd1);
`else
        applyStimulus('{1'b1, 1'b0, M_CALL, 16'h0000, 16'h0020, 16'h0080, 1'b0, 16'h0000, 3'd0}, "illegal_call");
        checkVal("underflow illegal call", 32'(err_underflow), 32'd1);
        applyStimulus('{1'b1, 1'b0, M_RET,  16'h0000, 16'h0021, 16'h0000, 1'b0, 16'h0000, 3'd0}, "illegal_ret");
        checkVal("underflow sticky", 32'(err_underflow), 32'd1);
`endif

        @(negedge clk);
        valid_in = 1'b0;
        checkVal("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
